// File: rtl/gd_pkg.sv
// Shared definitions for the gradient-descent quadratic minimiser: FSM encoding,
// saturation bounds and the fixed-point shift/accumulate/saturate helpers.
package gd_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRAD    = 3'd1,
    S_UPDATE  = 3'd2,
    S_EVAL_SQ = 3'd3,
    S_EVAL_Y  = 3'd4,
    S_DONE    = 3'd5
  } gd_state_e;

  // Widest DATA_W the helpers support; the working width holds a doubled
  // full product plus an accumulate term without wrapping.
  localparam int GD_MAX_W = 64;
  localparam int GD_ACC_W = 2 * GD_MAX_W + 2;

  function automatic logic signed [GD_ACC_W-1:0] sat_max(input int width);
    return (GD_ACC_W'(1) << (width - 1)) - GD_ACC_W'(1);
  endfunction

  function automatic logic signed [GD_ACC_W-1:0] sat_min(input int width);
    return -(GD_ACC_W'(1) << (width - 1));
  endfunction

  // acc +/- (prod >>> frac), exact at the working width.
  function automatic logic signed [GD_ACC_W-1:0] fx_shift_acc(
    input logic signed [GD_ACC_W-1:0] prod,
    input logic signed [GD_ACC_W-1:0] acc,
    input int                         frac,
    input logic                       sub
  );
    logic signed [GD_ACC_W-1:0] t;
    t = prod >>> frac;
    return sub ? (acc - t) : (acc + t);
  endfunction

  function automatic logic fx_ovf(input logic signed [GD_ACC_W-1:0] v, input int width);
    return (v > sat_max(width)) || (v < sat_min(width));
  endfunction

  function automatic logic signed [GD_ACC_W-1:0] fx_sat(input logic signed [GD_ACC_W-1:0] v,
                                                        input int width);
    if (v > sat_max(width)) return sat_max(width);
    if (v < sat_min(width)) return sat_min(width);
    return v;
  endfunction

endpackage

// File: rtl/gd_fx_mul.sv
// Fixed-point multiply unit: sat(acc +/- ((k*a*b) >>> FRAC_W)) with k = 1 or 2,
// reporting whether the result had to be clipped.
module gd_fx_mul
  import gd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 8,
  parameter bit DBL    = 1'b0,
  parameter bit SUB    = 1'b0
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  input  logic signed [DATA_W-1:0] i_acc,
  output logic signed [DATA_W-1:0] o_res,
  output logic                     o_ovf
);

  localparam int SH = DBL ? 1 : 0;

  logic signed [GD_ACC_W-1:0] w_prod;
  logic signed [GD_ACC_W-1:0] w_sum;

  assign w_prod = (GD_ACC_W'(i_a) * GD_ACC_W'(i_b)) <<< SH;
  assign w_sum  = fx_shift_acc(w_prod, GD_ACC_W'(i_acc), FRAC_W, SUB);
  assign o_res  = DATA_W'(fx_sat(w_sum, DATA_W));
  assign o_ovf  = fx_ovf(w_sum, DATA_W);

endmodule

// File: rtl/gd_quad_minimizer.sv
// Gradient-descent minimiser of y = a*x^2 + b*x + c as a start/done slave.
// Define GD_EARLY_STOP_EN to stop once |gradient| <= TOL.
module gd_quad_minimizer
  import gd_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 8,
  parameter int MAX_ITER = 50,
  parameter int TOL      = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_op,
  input  logic [DATA_W-1:0]                 x_init,
  input  logic [DATA_W-1:0]                 coef_a,
  input  logic [DATA_W-1:0]                 coef_b,
  input  logic [DATA_W-1:0]                 coef_c,
  input  logic [DATA_W-1:0]                 lr_in,
  output logic [DATA_W-1:0]                 x_at_min,
  output logic [2*DATA_W-1:0]               y_min,
  output logic [$clog2(MAX_ITER+1)-1:0]     iter_cnt,
  output logic                              sat_flag,
  output logic                              converged,
  output logic                              busy,
  output logic                              done_op
);

  localparam int IT_W = $clog2(MAX_ITER + 1);
  localparam int YW   = 2 * DATA_W + 1;
  localparam logic signed [DATA_W-1:0] TOL_P = DATA_W'(TOL);
`ifdef GD_EARLY_STOP_EN
  localparam bit EARLY_STOP = 1'b1;
`else
  localparam bit EARLY_STOP = 1'b0;
`endif

  gd_state_e                 r_state;
  logic signed [DATA_W-1:0]  r_x, r_a, r_b, r_c, r_lr, r_g;
  logic signed [2*DATA_W-1:0] r_s, r_y;
  logic [IT_W-1:0]           r_iter;
  logic                      r_sat, r_conv, r_busy, r_done, r_armed;

  logic signed [DATA_W-1:0]  w_g, w_x_next;
  logic                      w_g_ovf, w_x_ovf, w_g_small;
  logic signed [2*DATA_W-1:0] w_sq, w_y;

  gd_fx_mul #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .DBL(1'b1), .SUB(1'b0)) u_grad (
    .i_a   (r_a),
    .i_b   (r_x),
    .i_acc (r_b),
    .o_res (w_g),
    .o_ovf (w_g_ovf)
  );

  gd_fx_mul #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .DBL(1'b0), .SUB(1'b1)) u_upd (
    .i_a   (r_lr),
    .i_b   (r_g),
    .i_acc (r_x),
    .o_res (w_x_next),
    .o_ovf (w_x_ovf)
  );

  assign w_g_small = (w_g <= TOL_P) && (w_g >= -TOL_P);

  // Evaluation terms are deliberately unsaturated: x*x always fits 2*DATA_W.
  assign w_sq = ((2*DATA_W)'(r_x) * (2*DATA_W)'(r_x)) >>> FRAC_W;
  assign w_y  = (2*DATA_W)'((((YW'(r_a) * YW'(r_s)) + (YW'(r_b) * YW'(r_x))) >>> FRAC_W)
                            + YW'(r_c));

  // NOTE: every register here, datapath included, clears on rst_n so an aborted
  // run leaves no partial result on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_lr    <= '0;
      r_g     <= '0;
      r_s     <= '0;
      r_y     <= '0;
      r_iter  <= '0;
      r_sat   <= 1'b0;
      r_conv  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; every state reads last cycle's values.
      case (r_state)
        S_IDLE: begin
          if (!start_op) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_x     <= x_init;
            r_a     <= coef_a;
            r_b     <= coef_b;
            r_c     <= coef_c;
            r_lr    <= lr_in;
            r_iter  <= '0;
            r_sat   <= 1'b0;
            r_conv  <= 1'b0;
            r_busy  <= 1'b1;
            r_armed <= 1'b0;
            r_state <= S_GRAD;
          end
        end
        S_GRAD: begin
          r_g <= w_g;
          if (w_g_ovf) r_sat <= 1'b1;
          if (EARLY_STOP && w_g_small) begin
            r_conv  <= 1'b1;
            r_state <= S_EVAL_SQ;
          end else begin
            r_state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_x    <= w_x_next;
          r_iter <= r_iter + IT_W'(1);
          if (w_x_ovf) r_sat <= 1'b1;
          r_state <= (r_iter == IT_W'(MAX_ITER - 1)) ? S_EVAL_SQ : S_GRAD;
        end
        S_EVAL_SQ: begin
          r_s     <= w_sq;
          r_state <= S_EVAL_Y;
        end
        S_EVAL_Y: begin
          r_y     <= w_y;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!start_op) begin
            r_done  <= 1'b0;
            r_armed <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x_at_min  = r_x;
  assign y_min     = r_y;
  assign iter_cnt  = r_iter;
  assign sat_flag  = r_sat;
  assign converged = r_conv;
  assign busy      = r_busy;
  assign done_op   = r_done;

endmodule

// File: tb/tb_gd_quad_minimizer.sv
// Directed bench for gd_quad_minimizer at DATA_W=32, FRAC_W=8, MAX_ITER=50;
// expectations follow GD_EARLY_STOP_EN when the bench is built with it.
module tb_gd_quad_minimizer;

  localparam int DATA_W   = 32;
  localparam int MAX_ITER = 50;
  localparam int IT_W     = $clog2(MAX_ITER + 1);

`ifdef GD_EARLY_STOP_EN
  localparam int EXP_IT1   = 20;
  localparam int EXP_CYC1  = 44;
  localparam int EXP_CONV1 = 1;
`else
  localparam int EXP_IT1   = 50;
  localparam int EXP_CYC1  = 103;
  localparam int EXP_CONV1 = 0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start_op;
  logic [DATA_W-1:0]   x_init, coef_a, coef_b, coef_c, lr_in;
  logic [DATA_W-1:0]   x_at_min;
  logic [2*DATA_W-1:0] y_min;
  logic [IT_W-1:0]     iter_cnt;
  logic                sat_flag, converged, busy, done_op;

  int total = 0;
  int bad   = 0;
  int cyc;

  always #5 clk = ~clk;

  gd_quad_minimizer #(.DATA_W(32), .FRAC_W(8), .MAX_ITER(50), .TOL(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_op  (start_op),
    .x_init    (x_init),
    .coef_a    (coef_a),
    .coef_b    (coef_b),
    .coef_c    (coef_c),
    .lr_in     (lr_in),
    .x_at_min  (x_at_min),
    .y_min     (y_min),
    .iter_cnt  (iter_cnt),
    .sat_flag  (sat_flag),
    .converged (converged),
    .busy      (busy),
    .done_op   (done_op)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] x0, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] lr);
    x_init = x0;
    coef_a = a;
    coef_b = b;
    coef_c = c;
    lr_in  = lr;
  endtask

  // Raises start_op and counts edges, accept edge included, until done_op.
  // With scramble set, the inputs are overwritten right after the accept edge.
  task automatic run_to_done(input bit scramble, output int n);
    n = 0;
    start_op = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (scramble && n == 1) load(32'h7000_0000, 32'h1234, 32'h0, 32'h0, 32'h100);
    end while (done_op !== 1'b1 && n < 400);
    check("done_within_budget", 128'(done_op), 128'(1));
  endtask

  task automatic drop_start;
    start_op = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_case1(input string tag);
    check({tag, "_x"},    128'(x_at_min),  128'(32'h0000_0200));
    check({tag, "_y"},    128'(y_min),     128'(64'hFFFF_FFFF_FFFF_FF00));
    check({tag, "_iter"}, 128'(iter_cnt),  128'(EXP_IT1));
    check({tag, "_sat"},  128'(sat_flag),  128'(0));
    check({tag, "_conv"}, 128'(converged), 128'(EXP_CONV1));
    check({tag, "_busy"}, 128'(busy),      128'(0));
  endtask

  initial begin
    rst_n    = 1'b0;
    start_op = 1'b0;
    load(32'h0, 32'h100, 32'hFFFF_FC00, 32'h300, 32'h20);
    #12;
    check("rst_done", 128'(done_op),  128'(0));
    check("rst_busy", 128'(busy),     128'(0));
    check("rst_x",    128'(x_at_min), 128'(0));
    check("rst_y",    128'(y_min),    128'(0));
    check("rst_iter", 128'(iter_cnt), 128'(0));
    check("rst_sat",  128'(sat_flag), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Case 1: a=1.0, b=-4.0, c=3.0, lr=0.125 from x=0; minimum at x=2.0, y=-1.0.
    run_to_done(1'b0, cyc);
    check("c1_cycles", 128'(cyc), 128'(EXP_CYC1));
    check_case1("c1");

    // Holding start_op high after done must not start another run.
    repeat (5) @(posedge clk);
    #1;
    check("hold_done", 128'(done_op), 128'(1));
    check("hold_busy", 128'(busy),    128'(0));
    drop_start;
    check("idle_done", 128'(done_op),  128'(0));
    check("idle_keep", 128'(x_at_min), 128'(32'h0000_0200));

    // Rerun from x=4.0: floor rounding stalls the descent at 0x203 (g=6, step 0).
    load(32'h400, 32'h100, 32'hFFFF_FC00, 32'h300, 32'h20);
    run_to_done(1'b0, cyc);
    check("c5_x",    128'(x_at_min),  128'(32'h0000_0203));
    check("c5_y",    128'(y_min),     128'(64'hFFFF_FFFF_FFFF_FF00));
    check("c5_iter", 128'(iter_cnt),  128'(50));
    check("c5_conv", 128'(converged), 128'(0));
    drop_start;

    // Case 3: first gradient clips to +max, then x oscillates between -255 and 255.
    load(32'h7FFF_FF00, 32'h100, 32'h0, 32'h0, 32'h100);
    run_to_done(1'b0, cyc);
    check("c3_sat",  128'(sat_flag),  128'(1));
    check("c3_x",    128'(x_at_min),  128'(32'h0000_00FF));
    check("c3_y",    128'(y_min),     128'(64'h0000_0000_0000_00FE));
    check("c3_iter", 128'(iter_cnt),  128'(50));
    check("c3_conv", 128'(converged), 128'(0));
    drop_start;

    // Case 6: lr=0 leaves x at 1.5; y = 2.25 - 6 + 3 = -0.75.
    load(32'h180, 32'h100, 32'hFFFF_FC00, 32'h300, 32'h0);
    run_to_done(1'b0, cyc);
    check("c6_x",    128'(x_at_min), 128'(32'h0000_0180));
    check("c6_y",    128'(y_min),    128'(64'hFFFF_FFFF_FFFF_FF40));
    check("c6_iter", 128'(iter_cnt), 128'(50));
    check("c6_sat",  128'(sat_flag), 128'(0));
    drop_start;

    // Case 4: abort case 1 after ten updates.
    load(32'h0, 32'h100, 32'hFFFF_FC00, 32'h300, 32'h20);
    start_op = 1'b1;
    @(posedge clk);
    #1;
    check("c4_busy_start", 128'(busy), 128'(1));
    repeat (20) @(posedge clk);
    #1;
    check("c4_iter_mid", 128'(iter_cnt), 128'(10));
    check("c4_x_mid",    128'(x_at_min), 128'(32'h0000_01E5));
    rst_n    = 1'b0;
    start_op = 1'b0;
    #1;
    check("abort_done", 128'(done_op),  128'(0));
    check("abort_busy", 128'(busy),     128'(0));
    check("abort_x",    128'(x_at_min), 128'(0));
    check("abort_iter", 128'(iter_cnt), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Rerun case 1 while scrambling the inputs mid-run; latched values must win.
    run_to_done(1'b1, cyc);
    check("c4_cycles", 128'(cyc), 128'(EXP_CYC1));
    check_case1("c4");
    drop_start;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
